eth_packet_check: RTL
=====================

ETH_PACKET_CHECK -- requirements
Module: eth_packet_check

Interface
REQ-001 SHALL have parameter PACKET_COUNT, default 5, number of packets expected before done asserts.
REQ-002 SHALL have parameter PACKET_LENGTH, default 145, expected payload bytes per packet, excluding the FCS.
REQ-003 SHALL have port clk50  input  1  50 MHz RMII reference clock; the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx  input  2  RMII receive dibit, sampled every clk50.
REQ-006 SHALL have port crs_dv  input  1  carrier/data valid, high for the whole frame.
REQ-007 SHALL have port pkt_count  output  9  count of good packets.
REQ-008 SHALL have port err_count  output  9  count of bad packets.
REQ-009 SHALL have port error  output  1  sticky flag, set on the first bad packet.
REQ-010 SHALL have port done  output  1  high once pkt_count equals PACKET_COUNT.

Function
REQ-011 SHALL run the state machine IDLE, PREAMBLE, DATA, DROP; transitions are:
- IDLE to PREAMBLE on crs_dv=1 with rx=2'b01.
- IDLE to DROP on crs_dv=1 with any other rx value.
REQ-012 SHALL, in PREAMBLE:
- stay on rx=01;
- go to DATA on rx=11 (the SFD's last dibit);
- go to DROP on rx=00 or rx=10, with no error counted;
- return to IDLE on crs_dv=0, with no error counted.
REQ-013 SHALL, in DATA, assemble bytes LSB-first, one dibit per clk50: the first dibit is byte bits [1:0], the fourth is bits [7:6].
REQ-014 SHALL keep a 12-bit byte index, cleared on entry to DATA, and compare each completed payload byte against index[7:0]; any mismatch marks the packet bad.
REQ-015 SHALL evaluate the packet on the first cycle crs_dv=0 while in DATA:
- good only if the dibit phase is 0 (byte-aligned), the payload byte count equals PACKET_LENGTH, and no byte mismatched;
- otherwise bad.
REQ-016 SHALL, on a good packet, increment pkt_count one cycle after crs_dv falls, saturating at 511.
REQ-017 SHALL, on a bad packet, increment err_count (saturating at 511) and set error in that same cycle.
REQ-018 SHALL mark the packet bad as soon as the payload byte count exceeds PACKET_LENGTH (PACKET_LENGTH+4 bytes total with ETH_CHECK_CRC_EN), and stop comparing bytes; the packet is still counted once, when crs_dv falls.
REQ-019 SHALL, in DROP, ignore rx and return to IDLE on crs_dv=0.
REQ-020 SHALL combinationally assert done when pkt_count >= PACKET_COUNT; done stays high while further packets are still checked and counted.
REQ-021 SHALL drive error low until a bad packet, then hold it high until reset.
REQ-022 SHALL require crs_dv=0 for at least one cycle in IDLE before accepting a frame.

Reset
REQ-023 SHALL, with reset high at a clk50 edge, set the state to IDLE, pkt_count=0, err_count=0, error=0, and clear the byte index, dibit phase and CRC register.
REQ-024 SHALL, when reset deasserts mid-frame, not sync to the remainder of that frame (per REQ-022) and count nothing for it.

Configuration
REQ-025 SHALL, with macro ETH_CHECK_CRC_EN defined:
- treat the final 4 received bytes as the FCS;
- exclude the FCS from the payload count and the pattern compare;
- run CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) over all bytes including the FCS;
- additionally require the final CRC register to equal 0xDEBB20E3 for a good packet.
REQ-026 SHALL, without ETH_CHECK_CRC_EN, instantiate no CRC logic and treat all received bytes as payload.

Structure
REQ-027 SHALL place the state enum, the constants PREAMBLE_DIBIT=2'b01, SFD_DIBIT=2'b11, CRC_INIT and CRC_RESIDUE, and the 12-bit byte-index type in the shared package eth_pkg.
REQ-028 SHALL implement the CRC as sub-module eth_crc32 with a dibit-per-cycle update (inputs clk50, reset, clear, en, din[1:0]; output crc[31:0]), instantiated only under ETH_CHECK_CRC_EN.

Verification
REQ-029 SHALL cover: the matching transmitter with default parameters, 5 packets of 145 pattern bytes -> pkt_count=5, err_count=0, done=1, error=0.
REQ-030 SHALL cover: one packet with payload byte 37 corrupted to 0x00 -> err_count=1, error=1, pkt_count unchanged.
REQ-031 SHALL cover: a 144-byte packet and a 146-byte packet -> err_count=2, each counted on its own crs_dv fall.
REQ-032 SHALL cover: crs_dv dropping after dibit 2 of byte 100 -> alignment error, err_count increments by 1.
REQ-033 SHALL cover: reset pulsed at byte 50 of packet 2 -> all counters 0; the tail of packet 2 is ignored; packets 3-5 give pkt_count=3.
REQ-034 SHALL cover, under ETH_CHECK_CRC_EN: a valid FCS -> good; one FCS bit flipped -> err_count=1.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the RMII packet checker and its CRC sub-module.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  typedef logic [11:0] byte_idx_t;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY       = 32'hEDB8_8320;
  localparam int          FCS_BYTES      = 4;

endpackage

// File: rtl/eth_crc32.sv
// Reflected CRC-32 register advanced by one RMII dibit per clock, bit 0 first.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk50,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [31:0] crc
);

  logic [31:0] r_crc;

  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] v;
    v = c;
    for (int i = 0; i < 2; i++) begin
      v = (v >> 1) ^ (((v[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
    end
    return v;
  endfunction

  always_ff @(posedge clk50) begin
    if (reset || clear) begin
      r_crc <= CRC_INIT;
    end else if (en) begin
      r_crc <= crc_dibit(r_crc, din);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/eth_packet_check.sv
// RMII receive checker: syncs on preamble/SFD, checks an incrementing byte pattern and counts packets.
// Define ETH_CHECK_CRC_EN to treat the last four bytes as FCS and require a valid CRC-32 residue.
module eth_packet_check
  import eth_pkg::*;
#(
  parameter int PACKET_COUNT  = 5,
  parameter int PACKET_LENGTH = 145
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [1:0] rx,
  input  logic       crs_dv,
  output logic [8:0] pkt_count,
  output logic [8:0] err_count,
  output logic       error,
  output logic       done
);

`ifdef ETH_CHECK_CRC_EN
  localparam int TOTAL_LEN = PACKET_LENGTH + FCS_BYTES;
`else
  localparam int TOTAL_LEN = PACKET_LENGTH;
`endif
  localparam byte_idx_t TOTAL_IDX = byte_idx_t'(TOTAL_LEN);

  state_t    r_state;
  state_t    w_next;
  logic      r_armed;
  logic [1:0] r_phase;
  logic [5:0] r_shift;
  byte_idx_t r_idx;
  logic      r_bad;
  logic [8:0] r_pkt_count;
  logic [8:0] r_err_count;
  logic      r_error;

  logic       w_sfd;
  logic       w_rx_dibit;
  logic       w_eval;
  logic       w_byte_done;
  logic       w_good;
  logic [7:0] w_byte;
  logic       w_crc_ok;
  logic       w_cmp_en;
  logic [7:0] w_cmp_byte;
  logic [7:0] w_cmp_lo;

  function automatic logic [8:0] sat_inc(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  always_ff @(posedge clk50) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Frames are only accepted once crs_dv has been seen low since reset or the last frame.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (crs_dv && r_armed) begin
          w_next = (rx == PREAMBLE_DIBIT) ? ST_PREAMBLE : ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!crs_dv) begin
          w_next = ST_IDLE;
        end else if (rx == SFD_DIBIT) begin
          w_next = ST_DATA;
        end else if (rx != PREAMBLE_DIBIT) begin
          w_next = ST_DROP;
        end
      end
      ST_DATA, ST_DROP: begin
        if (!crs_dv) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sfd      = 1'b0;
    w_rx_dibit = 1'b0;
    w_eval     = 1'b0;
    case (r_state)
      ST_PREAMBLE: w_sfd = crs_dv && (rx == SFD_DIBIT);
      ST_DATA: begin
        w_rx_dibit = crs_dv;
        w_eval     = !crs_dv;
      end
      default: ;
    endcase
  end

  assign w_byte      = {rx, r_shift};
  assign w_byte_done = w_rx_dibit && (r_phase == 2'd3);

`ifdef ETH_CHECK_CRC_EN
  logic [31:0] w_crc;
  logic [31:0] r_dly;

  eth_crc32 u_crc32 (
    .clk50 (clk50),
    .reset (reset),
    .clear (w_sfd),
    .en    (w_rx_dibit),
    .din   (rx),
    .crc   (w_crc)
  );

  // Payload bytes are compared four bytes late, once they are known not to be FCS.
  always_ff @(posedge clk50) begin
    if (w_byte_done) begin
      r_dly <= {r_dly[23:0], w_byte};
    end
  end

  assign w_crc_ok   = (w_crc == CRC_RESIDUE);
  assign w_cmp_en   = (r_idx >= byte_idx_t'(FCS_BYTES));
  assign w_cmp_byte = r_dly[31:24];
  assign w_cmp_lo   = r_idx[7:0] - 8'(FCS_BYTES);
`else
  assign w_crc_ok   = 1'b1;
  assign w_cmp_en   = 1'b1;
  assign w_cmp_byte = w_byte;
  assign w_cmp_lo   = r_idx[7:0];
`endif

  assign w_good = (r_phase == 2'd0) && (r_idx == TOTAL_IDX) && !r_bad && w_crc_ok;

  always_ff @(posedge clk50) begin
    if (reset) begin
      r_armed     <= 1'b0;
      r_phase     <= 2'd0;
      r_idx       <= '0;
      r_bad       <= 1'b0;
      r_pkt_count <= 9'd0;
      r_err_count <= 9'd0;
      r_error     <= 1'b0;
    end else begin
      r_armed <= !crs_dv || ((r_state == ST_IDLE) && r_armed);
      if (w_sfd) begin
        r_phase <= 2'd0;
        r_idx   <= '0;
        r_bad   <= 1'b0;
      end else if (w_rx_dibit) begin
        r_phase <= r_phase + 2'd1;
        if (w_byte_done) begin
          if (r_idx != '1) begin
            r_idx <= r_idx + byte_idx_t'(1);
          end
          if (r_idx >= TOTAL_IDX) begin
            r_bad <= 1'b1;
          end else if (w_cmp_en && (w_cmp_byte != w_cmp_lo)) begin
            r_bad <= 1'b1;
          end
        end
      end
      if (w_eval) begin
        if (w_good) begin
          r_pkt_count <= sat_inc(r_pkt_count);
        end else begin
          r_err_count <= sat_inc(r_err_count);
          r_error     <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (w_rx_dibit) begin
      r_shift <= {rx, r_shift[5:2]};
    end
  end

  assign pkt_count = r_pkt_count;
  assign err_count = r_err_count;
  assign error     = r_error;
  assign done      = (int'(r_pkt_count) >= PACKET_COUNT);

endmodule
